fft_sample_fetcher: RTL and testbench
=====================================

// Module: fft_sample_fetcher
// PURPOSE
//  Read-side master for the sample RAM's cache port. Launches a frame of 2^LOG2N reads
//  (bit-reversed or linear index order) and returns the 16-bit samples to the FFT core.
//  Delivery is a valid/ready stream with backpressure. Sits between the RAM
//  (read_ram_to_cache / cir_data_out, 1-cycle read latency) and the butterfly cache.
// PARAMETERS
//  LOG2N     3     log2 of frame length (1..12); frame = 2^LOG2N samples
//  ADR_W     12    RAM address width
//  DATA_W    16    sample width returned by RAM
//  BIT_REV   1     1: index order bit-reversed over LOG2N bits; 0: linear order
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       1-cycle pulse; begins a frame when idle
//  base_adr      in   ADR_W   frame base address, sampled on accepted start
//  busy          out  1       high from accepted start until done pulse (inclusive)
//  done          out  1       1-cycle pulse after final sample handshaked
//  ram_rd_en     out  1       read issued this cycle
//  ram_rd_adr    out  ADR_W   read address (to read_ram_to_cache)
//  ram_rd_data   in   DATA_W  read data, valid exactly 1 cycle after ram_rd_en
//  s_data        out  DATA_W  sample to FFT core
//  s_valid       out  1       s_data valid
//  s_ready       in   1       FFT core accepts; transfer = s_valid & s_ready
//  s_last        out  1       high with final sample of frame
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/FIFO cleared. rst mid-frame aborts
//   immediately; in-flight read data is discarded, no done pulse.
//  FSM: IDLE -(start)-> FETCH -(last read issued)-> DRAIN -(last sample out)-> DONE -> IDLE.
//   DONE lasts 1 cycle: done=1, busy=1. start ignored in any state but IDLE.
//  Issue index idx counts 0..2^LOG2N-1. ram_rd_adr = base_adr + (BIT_REV ? bitrev(idx) : idx),
//   sum taken modulo 2^ADR_W (wraps at top of RAM).
//  Output buffer: 2-entry FIFO. inflight = ram_rd_en of previous cycle (0/1).
//   Read issued in FETCH only when fifo_cnt + inflight - pop < 2 (pop = s_valid & s_ready),
//   so FIFO never overflows; no RAM data is ever dropped.
//  Captured data is written into FIFO on the cycle after ram_rd_en.
//  s_valid = fifo nonempty; s_data/s_last from FIFO head, hold stable while s_valid & !s_ready.
//  s_last tagged on the entry from idx = 2^LOG2N-1.
//  Simultaneous push+pop with full FIFO cannot occur (credit rule); push+pop at cnt=1 keeps cnt=1.
//  Throughput: 1 sample/cycle with s_ready held high; first s_valid 2 cycles after start.
//  ram_rd_en is 0 in IDLE, DRAIN and DONE.
// TESTING
//  LOG2N=3, BIT_REV=1, base 0x000, RAM[i]=0x1000+i, s_ready=1 -> s_data 1000,1004,1002,1006,
//   1001,1005,1003,1007; s_last on 8th; done 1 cycle after; 8 consecutive valid cycles.
//  Same frame, s_ready toggled 1,0,0,1 repeatedly -> identical sequence, no loss/dup,
//   s_data stable while stalled, never >2 reads outstanding+buffered.
//  BIT_REV=0, base 0xFFE, LOG2N=2 -> addresses FFE,FFF,000,001 (wrap), data in that order.
//  start pulsed again mid-frame -> ignored; exactly 8 samples and one done pulse.
//  rst asserted after 3rd sample -> all outputs 0 asynchronously; new start replays full
//   frame from idx 0 correctly.
//  s_ready=0 for 20 cycles after start -> exactly 2 reads issued, then none until ready.

Source files
------------

// File: rtl/fft_sample_fetcher.sv
// Read-side master for the sample RAM cache port: fetches one frame of 2^LOG2N samples
// (bit-reversed or linear order) and streams them out with valid/ready backpressure.
module fft_sample_fetcher #(
  parameter int unsigned LOG2N   = 3,
  parameter int unsigned ADR_W   = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BIT_REV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  base_adr,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADR_W-1:0]  ram_rd_adr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] s_data,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_last
);

  localparam int unsigned N = 1 << LOG2N;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [LOG2N-1:0]   idx_q, idx_d;
  logic [ADR_W-1:0]   base_q, base_d;
  logic               inflight_q, inflight_last_q;
  logic [DATA_W-1:0]  fifo_data_q [2];
  logic               fifo_last_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         cnt_q;

  logic               pop, issue, last_issue, head_last;
  logic [2:0]         occ;
  logic [LOG2N-1:0]   off;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = v[int'(LOG2N)-1-i];
    return r;
  endfunction

  assign s_valid   = (cnt_q != 2'd0);
  assign pop       = s_valid & s_ready;
  assign head_last = fifo_last_q[rd_ptr_q];
  // Credit: buffered + in-flight entries after this cycle's pop must leave room for one more.
  assign occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign issue      = (state_q == StFetch) && (occ < 3'd2);
  assign last_issue = issue && (idx_q == LOG2N'(N - 1));
  assign off        = (BIT_REV != 0) ? bitrev(idx_q) : idx_q;

  assign ram_rd_en  = issue;
  assign ram_rd_adr = issue ? (base_q + ADR_W'(off)) : '0;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign s_data     = s_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign s_last     = s_valid & head_last;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          idx_d   = '0;
          base_d  = base_adr;
        end
      end
      StFetch: begin
        if (issue) begin
          idx_d = idx_q + 1'b1;
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && head_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      base_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      base_q          <= base_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
    end
  end

  // Returning RAM data is pushed the cycle after its read; the credit rule guarantees space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= ram_rd_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fft_sample_fetcher.sv
// Bench for fft_sample_fetcher: two instances (bit-reversed N=8, linear N=4) checked each cycle
// against a frame-level model, plus literal expectations for the directed scenarios.
module tb_fft_sample_fetcher;

  logic        clk, rst;
  logic        start_a, busy_a, done_a, rd_en_a, s_valid_a, s_ready_a, s_last_a;
  logic [11:0] base_a, adr_a;
  logic [15:0] rd_data_a, s_data_a;
  logic        start_b, busy_b, done_b, rd_en_b, s_valid_b, s_ready_b, s_last_b;
  logic [11:0] base_b, adr_b;
  logic [15:0] rd_data_b, s_data_b;

  fft_sample_fetcher #(.LOG2N(3), .ADR_W(12), .DATA_W(16), .BIT_REV(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .base_adr(base_a), .busy(busy_a), .done(done_a),
    .ram_rd_en(rd_en_a), .ram_rd_adr(adr_a), .ram_rd_data(rd_data_a), .s_data(s_data_a),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_last(s_last_a)
  );

  fft_sample_fetcher #(.LOG2N(2), .ADR_W(12), .DATA_W(16), .BIT_REV(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .base_adr(base_b), .busy(busy_b), .done(done_b),
    .ram_rd_en(rd_en_b), .ram_rd_adr(adr_b), .ram_rd_data(rd_data_b), .s_data(s_data_b),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_last(s_last_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM contents: RAM[a] = 0x1000 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= 16'h1000 + {4'h0, adr_a};
    if (rd_en_b) rd_data_b <= 16'h1000 + {4'h0, adr_b};
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_adr(input int unsigned base, input int unsigned k,
                                          input int unsigned log2n, input bit brev);
    int unsigned r;
    r = k;
    if (brev) begin
      r = 0;
      for (int b = 0; b < int'(log2n); b++) if (k[b]) r |= 1 << (log2n - 1 - b);
    end
    return (base + r) % 4096;
  endfunction

  // Frame-level model state, one slot per DUT.
  bit          active [2], done_due [2], pstall [2], plast [2];
  int unsigned iss [2], pops [2], base_m [2], run [2], max_run [2], rd_cnt [2], done_cnt [2];
  int unsigned pdata [2];
  int unsigned a_dlog [$];
  int unsigned b_dlog [$];
  int unsigned b_alog [$];

  task automatic model_cycle(input int d, input int unsigned log2n, input bit brev,
                             input logic start, input logic busy, input logic done,
                             input logic rd_en, input logic [11:0] adr, input logic vld,
                             input logic rdy, input logic [15:0] data, input logic last,
                             input logic [11:0] badr);
    int unsigned n;
    bit acc, was_active;
    n = 1 << log2n;
    if (rst) begin
      chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0); chk("rst_adr", adr, 0);
      chk("rst_valid", vld, 0);   chk("rst_data", data, 0);
      chk("rst_last", last, 0);
      active[d] = 0; done_due[d] = 0; iss[d] = 0; pops[d] = 0; pstall[d] = 0; run[d] = 0;
      return;
    end
    acc        = start && !active[d];
    was_active = active[d];
    chk("busy", busy, active[d]);
    chk("done", done, done_due[d]);
    if (done) done_cnt[d]++;
    if (done_due[d]) begin
      active[d]   = 0;
      done_due[d] = 0;
    end
    if (rd_en) begin
      rd_cnt[d]++;
      chk("rd_en_in_frame", (was_active && iss[d] < n) ? 1 : 0, 1);
      chk("rd_adr", adr, exp_adr(base_m[d], iss[d], log2n, brev));
      if (d == 1) b_alog.push_back(adr);
      iss[d]++;
    end
    if (pstall[d]) begin
      chk("stall_valid", vld, 1);
      chk("stall_data", data, pdata[d]);
      chk("stall_last", last, plast[d]);
    end
    if (vld) begin
      run[d]++;
      if (run[d] > max_run[d]) max_run[d] = run[d];
    end else run[d] = 0;
    if (vld && rdy) begin
      chk("s_data", data, (exp_adr(base_m[d], pops[d], log2n, brev) + 'h1000) & 'hFFFF);
      chk("s_last", last, (pops[d] == n - 1) ? 1 : 0);
      if (d == 0) a_dlog.push_back(data); else b_dlog.push_back(data);
      pops[d]++;
      if (pops[d] == n) done_due[d] = 1;
    end
    chk("credit", (iss[d] - pops[d] <= 2) ? 1 : 0, 1);
    pstall[d] = vld && !rdy;
    pdata[d]  = data;
    plast[d]  = last;
    if (acc) begin
      active[d] = 1; iss[d] = 0; pops[d] = 0; base_m[d] = badr;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 3, 1'b1, start_a, busy_a, done_a, rd_en_a, adr_a, s_valid_a, s_ready_a,
                s_data_a, s_last_a, base_a);
    model_cycle(1, 2, 1'b0, start_b, busy_b, done_b, rd_en_b, adr_b, s_valid_b, s_ready_b,
                s_data_b, s_last_b, base_b);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle_a(input int limit, input bit toggle);
    bit pat [4];
    bit ok;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ok  = 0;
    for (int i = 0; i < limit; i++) begin
      if (toggle) s_ready_a = pat[i % 4];
      step();
      if (!busy_a) begin
        ok = 1;
        break;
      end
    end
    s_ready_a = 1'b1;
    if (!ok) chk("timeout_a", 0, 1);
  endtask

  task automatic check_frame_a(input string tag);
    int unsigned exp_rev [8];
    exp_rev = '{'h1000, 'h1004, 'h1002, 'h1006, 'h1001, 'h1005, 'h1003, 'h1007};
    chk({tag, "_len"}, a_dlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < a_dlog.size()) chk({tag, "_seq"}, a_dlog[i], exp_rev[i]);
  endtask

  task automatic start_frame_a();
    a_dlog.delete();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    int unsigned d0, r0;
    int unsigned exp_wa [4];
    bit ok;
    rst = 1'b0;
    start_a = 1'b0; base_a = 12'h000; s_ready_a = 1'b1;
    start_b = 1'b0; base_b = 12'h000; s_ready_b = 1'b1;
    #1 rst = 1'b1;
    step(); step();
    chk("reset_busy", busy_a, 0);
    chk("reset_valid", s_valid_a, 0);
    rst = 1'b0;
    step();

    // Bit-reversed frame, ready held high.
    d0 = done_cnt[0]; max_run[0] = 0;
    start_frame_a();
    wait_idle_a(100, 1'b0);
    check_frame_a("t1");
    chk("t1_done_cnt", done_cnt[0] - d0, 1);
    chk("t1_valid_run", max_run[0], 8);

    // Same frame with ready toggling 1,0,0,1.
    d0 = done_cnt[0];
    start_frame_a();
    wait_idle_a(400, 1'b1);
    check_frame_a("t2");
    chk("t2_done_cnt", done_cnt[0] - d0, 1);

    // Linear order, wrapping at the top of RAM.
    b_alog.delete(); b_dlog.delete();
    base_b = 12'hFFE;
    start_b = 1'b1; step(); start_b = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy_b) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_b", 0, 1);
    exp_wa = '{'hFFE, 'hFFF, 'h000, 'h001};
    chk("t3_adr_len", b_alog.size(), 4);
    chk("t3_data_len", b_dlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_alog.size()) chk("t3_adr", b_alog[i], exp_wa[i]);
      if (i < b_dlog.size()) chk("t3_data", b_dlog[i], 'h1000 + exp_wa[i]);
    end

    // Start pulsed again mid-frame is ignored.
    d0 = done_cnt[0];
    start_frame_a();
    step(); step(); step();
    start_a = 1'b1; step(); start_a = 1'b0;
    wait_idle_a(100, 1'b0);
    check_frame_a("t4");
    chk("t4_done_cnt", done_cnt[0] - d0, 1);

    // Asynchronous reset after the third sample, then a clean replay.
    d0 = done_cnt[0];
    start_frame_a();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_dlog.size() >= 3) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("timeout_t5", 0, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy", busy_a, 0);     chk("t5_done", done_a, 0);
    chk("t5_rd_en", rd_en_a, 0);   chk("t5_adr", adr_a, 0);
    chk("t5_valid", s_valid_a, 0); chk("t5_data", s_data_a, 0);
    chk("t5_last", s_last_a, 0);
    step();
    rst = 1'b0;
    chk("t5_no_done", done_cnt[0] - d0, 0);
    step();
    start_frame_a();
    wait_idle_a(100, 1'b0);
    check_frame_a("t5");
    chk("t5_done_cnt", done_cnt[0] - d0, 1);

    // Ready held low: only two reads may be launched.
    s_ready_a = 1'b0;
    r0 = rd_cnt[0];
    start_frame_a();
    s_ready_a = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("t6_reads_stalled", rd_cnt[0] - r0, 2);
    s_ready_a = 1'b1;
    wait_idle_a(100, 1'b0);
    check_frame_a("t6");
    chk("t6_reads_total", rd_cnt[0] - r0, 8);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
